// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared constants and state encoding for the sequential divider
package div_seq_pkg;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - EX-stage to divider request/response bundle
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   div_opdata1_i;
  logic [WIDTH-1:0]   div_opdata2_i;
  logic               div_start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] div_result_o;
  logic               div_ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i, div_opdata1_i, div_opdata2_i, div_start_i, annul_i,
    input  div_result_o, div_ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, div_opdata1_i, div_opdata2_i, div_start_i, annul_i,
    output div_result_o, div_ready_o, busy_o
  );
endinterface

// File: rtl/div_seq_step.sv
// rtl/div_seq_step.sv - one restoring-division iteration (shift, trial subtract, restore)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] i_work,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [2*WIDTH:0] o_work
);

  // Partial remainder shifted left with the next dividend bit already in place.
  logic [WIDTH+1:0] w_partial;
  logic [WIDTH+1:0] w_trial;

  assign w_partial = i_work[2*WIDTH:WIDTH-1];
  assign w_trial   = w_partial - {2'b00, i_divisor};

  always_comb begin
    if (!w_trial[WIDTH+1]) begin
      o_work = {w_trial[WIDTH:0], i_work[WIDTH-2:0], 1'b1};
    end else begin
      o_work = {w_partial[WIDTH:0], i_work[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle DIV/DIVU sequencer with EX start/ready handshake and flush abort
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  div_state_t         r_state;
  div_state_t         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]   r_work;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_q_neg;
  logic               r_r_neg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  logic [2*WIDTH:0]   w_step_work;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_result_nxt;
  logic               w_ready_nxt;
  logic               w_start;
  logic               w_done;
  logic               w_sign1;
  logic               w_sign2;

  assign w_start = (bus.div_start_i == DivStart);
  assign w_done  = (r_cnt == CNT_W'(WIDTH));
  assign w_sign1 = bus.signed_div_i & bus.div_opdata1_i[WIDTH-1];
  assign w_sign2 = bus.signed_div_i & bus.div_opdata2_i[WIDTH-1];
  assign w_mag1  = w_sign1 ? -bus.div_opdata1_i : bus.div_opdata1_i;
  assign w_mag2  = w_sign2 ? -bus.div_opdata2_i : bus.div_opdata2_i;
  assign w_quot  = r_q_neg ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
  assign w_rem   = r_r_neg ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_step_work)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next;
  end

  // Flush beats everything; dropping start mid-run means EX replaced the instruction.
  always_comb begin
    w_next = r_state;
    if (bus.annul_i) begin
      w_next = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE:    if (w_start) w_next = (bus.div_opdata2_i == '0) ? DIV_DIVZERO : DIV_ON;
        DIV_DIVZERO: w_next = w_start ? DIV_END : DIV_IDLE;
        DIV_ON:      if (!w_start) w_next = DIV_IDLE;
                     else if (w_done) w_next = DIV_END;
        DIV_END:     if (!w_start) w_next = DIV_IDLE;
        default:     w_next = DIV_IDLE;
      endcase
    end
  end

  // Divide-by-zero reaches END with result cleared; ready rises from END one edge later.
  always_comb begin
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
    if (w_next == DIV_IDLE) begin
      w_result_nxt = '0;
      w_ready_nxt  = DivResultNotReady;
    end else begin
      case (r_state)
        DIV_DIVZERO: begin
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end
        DIV_ON: if (w_done) begin
          w_result_nxt = {w_rem, w_quot};
          w_ready_nxt  = DivResultReady;
        end
        DIV_END:  w_ready_nxt = DivResultReady;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= (w_next != DIV_IDLE);
      if (r_state == DIV_IDLE && w_next == DIV_ON) begin
        r_cnt     <= '0;
        r_work    <= {{(WIDTH+1){1'b0}}, w_mag1};
        r_divisor <= w_mag2;
        r_q_neg   <= w_sign1 ^ w_sign2;
        r_r_neg   <= w_sign1;
      end else if (r_state == DIV_ON && !w_done) begin
        r_work <= w_step_work;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.div_result_o = r_result;
  assign bus.div_ready_o  = r_ready;
  assign bus.busy_o       = r_busy;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed and random checks of div_seq against an arithmetic reference
module tb_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.div_start_i   = 1'b0;
    bus.annul_i       = 1'b0;
    bus.signed_div_i  = 1'b0;
    bus.div_opdata1_i = '0;
    bus.div_opdata2_i = '0;
  endtask

  // Full handshake: start held until ready, optional stall cycles in END, then release.
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int cyc;
    bit got;
    exp = ref_div(sgn, a, b);
    bus.signed_div_i  = sgn;
    bus.div_opdata1_i = a;
    bus.div_opdata2_i = b;
    bus.div_start_i   = 1'b1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, {63'd0, bus.busy_o}, 64'd1);
      if (bus.div_ready_o === 1'b1) got = 1;
    end
    check({tag, "_latency"}, 64'(cyc), (b == 32'd0) ? 64'd3 : 64'd34);
    check({tag, "_result"}, bus.div_result_o, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_ready"}, {63'd0, bus.div_ready_o}, 64'd1);
      check({tag, "_hold_result"}, bus.div_result_o, exp);
    end
    bus.div_start_i = 1'b0;
    tick();
    check({tag, "_drop_ready"}, {63'd0, bus.div_ready_o}, 64'd0);
    check({tag, "_drop_busy"}, {63'd0, bus.busy_o}, 64'd0);
    check({tag, "_drop_result"}, bus.div_result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    idle_inputs();
    bus.div_start_i   = 1'b1;
    bus.div_opdata1_i = 32'd50;
    bus.div_opdata2_i = 32'd5;
    tick();
    tick();
    check("reset_ready", {63'd0, bus.div_ready_o}, 64'd0);
    check("reset_busy", {63'd0, bus.busy_o}, 64'd0);
    check("reset_result", bus.div_result_o, 64'd0);
    idle_inputs();
    rst = 1'b0;
    tick();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
    check("divu_100_7_lit", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div("div_by0", 1'b1, 32'd1234, 32'd0, 0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lit", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});

    // Flush in the middle of a run.
    bus.signed_div_i  = 1'b0;
    bus.div_opdata1_i = 32'd999;
    bus.div_opdata2_i = 32'd3;
    bus.div_start_i   = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    bus.annul_i     = 1'b1;
    bus.div_start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    check("annul_ready", {63'd0, bus.div_ready_o}, 64'd0);
    check("annul_busy", {63'd0, bus.busy_o}, 64'd0);
    check("annul_result", bus.div_result_o, 64'd0);
    run_div("after_annul", 1'b0, 32'hFFFF_FFFF, 32'h10, 0);

    run_div("stall_end", 1'b1, 32'hFFFF_FC18, 32'd7, 5);

    // Synchronous reset mid-division.
    bus.signed_div_i  = 1'b0;
    bus.div_opdata1_i = 32'd12345;
    bus.div_opdata2_i = 32'd11;
    bus.div_start_i   = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_ready", {63'd0, bus.div_ready_o}, 64'd0);
    check("rst_mid_busy", {63'd0, bus.busy_o}, 64'd0);
    check("rst_mid_result", bus.div_result_o, 64'd0);
    rst = 1'b0;
    bus.div_start_i = 1'b0;
    tick();

    // EX withdraws start mid-run, then issues a different division.
    bus.signed_div_i  = 1'b1;
    bus.div_opdata1_i = 32'd77;
    bus.div_opdata2_i = 32'd5;
    bus.div_start_i   = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.div_start_i = 1'b0;
    tick();
    check("drop_on_busy", {63'd0, bus.busy_o}, 64'd0);
    check("drop_on_ready", {63'd0, bus.div_ready_o}, 64'd0);
    run_div("after_drop", 1'b1, 32'h8765_4321, 32'h0000_1234, 0);

    for (int n = 0; n < 8; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = $urandom_range(1, 1000);
      run_div($sformatf("rand%0d", n), rs, ra, rb, n % 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
